// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline register: full-throughput valid/ready stage with
// registered in_ready, flush, occupancy and a saturating downstream-bubble counter.
module pipe_stage_reg #(
  parameter int DW   = 128,
  parameter int CW   = 16,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      occupancy,
  output logic [CNTW-1:0] bubble_cnt
);

  if (DW < 8 || DW > 512) begin : g_bad_dw
    $fatal(1, "pipe_stage_reg: DW=%0d outside 8..512", DW);
  end
  if (CW < 1 || CW > DW) begin : g_bad_cw
    $fatal(1, "pipe_stage_reg: CW=%0d outside 1..DW", CW);
  end
  if (CNTW < 1) begin : g_bad_cntw
    $fatal(1, "pipe_stage_reg: CNTW=%0d must be at least 1", CNTW);
  end

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] data;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   enq, deq;

  // in_ready depends only on the skid flop, so out_ready never reaches it combinationally
  assign in_ready  = ~skid_q.vld;
  assign out_valid = main_q.vld;
  assign out_data  = main_q.data;
  assign enq       = in_valid & in_ready;
  assign deq       = main_q.vld & out_ready;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d.vld          = 1'b0;
      skid_d.vld          = 1'b0;
      main_d.data[CW-1:0] = '0;
    end else if (!main_q.vld) begin
      if (enq) main_d = '{vld: 1'b1, data: in_data};
    end else if (!deq) begin
      if (enq) skid_d = '{vld: 1'b1, data: in_data};
    end else if (skid_q.vld) begin
      main_d     = skid_q;
      skid_d.vld = 1'b0;
    end else if (enq) begin
      main_d = '{vld: 1'b1, data: in_data};
    end else begin
      main_d.vld = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_q     <= '0;
      skid_q     <= '0;
      occupancy  <= 2'd0;
      bubble_cnt <= '0;
    end else begin
      main_q    <= main_d;
      skid_q    <= skid_d;
      occupancy <= {1'b0, main_d.vld} + {1'b0, skid_d.vld};
      // a bubble is a cycle where downstream could take data but none is offered
      if (!main_q.vld && out_ready && !flush && (bubble_cnt != {CNTW{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
